// File: rtl/sprite_pkg.sv
// Shared sprite types, the two 8x8 pixel patterns and the pixel lookup helper.
// Row bit x is pixel x; odd frames use pattern 1, even frames pattern 0.
package sprite_pkg;

    typedef logic [7:0] SPR_ROW_T;

    localparam SPR_ROW_T [7:0] PAT0 = {
        8'h14, 8'h14, 8'h1E, 8'h3F,
        8'h39, 8'h30, 8'hF0, 8'h70
    };

    localparam SPR_ROW_T [7:0] PAT1 = {
        8'h20, 8'h24, 8'h1E, 8'h3F,
        8'h39, 8'h30, 8'hF0, 8'h70
    };

    function automatic logic sprite_bit(
        input int unsigned frame,
        input int unsigned y,
        input int unsigned x
    );
        SPR_ROW_T row;
        logic     odd;
        odd = (frame % 2) == 1;
        if (y > 7 || x > 7) begin
            return 1'b0;
        end
        row = odd ? PAT1[y[2:0]] : PAT0[y[2:0]];
        return row[x[2:0]];
    endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Animation time base: counts ticks and advances the pending frame,
// with a force path that overrides stepping in the same cycle.
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int N_FRAMES        = 4,
    parameter int TICKS_PER_FRAME = 6,
    parameter int FW              = $clog2(N_FRAMES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_tick,
    input  logic          i_anim_en,
    input  logic          i_frame_force,
    input  logic [FW-1:0] i_frame_idx,
    output logic [FW-1:0] o_next_frame
);

    localparam int CW = $clog2(TICKS_PER_FRAME) + 1;
    localparam logic [CW-1:0] LAST_TICK  = CW'(TICKS_PER_FRAME - 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(N_FRAMES - 1);

    logic [CW-1:0] tick_cnt;
    logic [CW-1:0] tick_d;
    logic [FW-1:0] next_frame;
    logic [FW-1:0] next_d;

    always_comb begin
        tick_d = tick_cnt;
        next_d = next_frame;
        if (i_frame_force) begin
            tick_d = '0;
            next_d = (i_frame_idx > LAST_FRAME) ? LAST_FRAME : i_frame_idx;
        end else if (i_anim_en && i_tick) begin
            if (tick_cnt == LAST_TICK) begin
                tick_d = '0;
                next_d = (next_frame == LAST_FRAME) ? '0 : next_frame + 1'b1;
            end else begin
                tick_d = tick_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt   <= '0;
            next_frame <= '0;
        end else begin
            tick_cnt   <= tick_d;
            next_frame <= next_d;
        end
    end

    assign o_next_frame = next_frame;

endmodule

// File: rtl/sprite_rom_anim.sv
// Animated sprite ROM: one pixel per request, latency 1, with mirroring.
// The displayed frame only switches on an address-0 read, so scans never tear.
module sprite_rom_anim
    import sprite_pkg::*;
#(
    parameter int SPR_W           = 8,
    parameter int SPR_H           = 8,
    parameter int N_FRAMES        = 4,
    parameter int BPP             = 1,
    parameter int TICKS_PER_FRAME = 6,
    parameter int AW              = $clog2(SPR_W * SPR_H),
    parameter int FW              = $clog2(N_FRAMES)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [AW-1:0]  i_rom_counter,
    input  logic           i_req,
    input  logic           i_flip_x,
    input  logic           i_tick,
    input  logic           i_anim_en,
    input  logic           i_frame_force,
    input  logic [FW-1:0]  i_frame_idx,
    output logic [BPP-1:0] o_sprite_color,
    output logic           o_valid,
    output logic [FW-1:0]  o_frame
);

    localparam int XW = $clog2(SPR_W);
    localparam int YW = AW - XW;

    logic [XW-1:0] x;
    logic [XW-1:0] x_eff;
    logic [YW-1:0] y;
    logic [FW-1:0] next_frame;
    logic [FW-1:0] disp_frame;
    logic [FW-1:0] sel_frame;
    logic          pix;

    sprite_anim_ctrl #(
        .N_FRAMES        (N_FRAMES),
        .TICKS_PER_FRAME (TICKS_PER_FRAME),
        .FW              (FW)
    ) u_ctrl (
        .clk           (clk),
        .rst           (rst),
        .i_tick        (i_tick),
        .i_anim_en     (i_anim_en),
        .i_frame_force (i_frame_force),
        .i_frame_idx   (i_frame_idx),
        .o_next_frame  (next_frame)
    );

    assign x = i_rom_counter[XW-1:0];
    assign y = i_rom_counter[AW-1:XW];

    // SPR_W is a power of two, so SPR_W-1-x is the bitwise inverse
    assign x_eff = i_flip_x ? ~x : x;

    assign sel_frame = (i_req && i_rom_counter == '0) ? next_frame : disp_frame;

    assign pix = sprite_bit(32'(sel_frame), 32'(y), 32'(x_eff));

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_frame     <= '0;
            o_valid        <= 1'b0;
            o_sprite_color <= '0;
        end else begin
            disp_frame <= sel_frame;
            o_valid    <= i_req;
            if (i_req) begin
                o_sprite_color <= {BPP{pix}};
            end
        end
    end

    assign o_frame = disp_frame;

endmodule

// File: tb/tb_sprite_rom_anim.sv
// Directed bench: table of read vectors plus animation/force/reset sequences.
module tb_sprite_rom_anim;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] addr;
    logic       req;
    logic       flip;
    logic       tick;
    logic       anim_en;
    logic       force_f;
    logic [1:0] fidx;
    logic [0:0] color;
    logic       valid;
    logic [1:0] frame;
    logic [0:0] color3;
    logic       valid3;
    logic [1:0] frame3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_rom_anim dut (
        .clk            (clk),
        .rst            (rst),
        .i_rom_counter  (addr),
        .i_req          (req),
        .i_flip_x       (flip),
        .i_tick         (tick),
        .i_anim_en      (anim_en),
        .i_frame_force  (force_f),
        .i_frame_idx    (fidx),
        .o_sprite_color (color),
        .o_valid        (valid),
        .o_frame        (frame)
    );

    sprite_rom_anim #(.N_FRAMES(3)) dut3 (
        .clk            (clk),
        .rst            (rst),
        .i_rom_counter  (addr),
        .i_req          (req),
        .i_flip_x       (flip),
        .i_tick         (tick),
        .i_anim_en      (anim_en),
        .i_frame_force  (force_f),
        .i_frame_idx    (fidx),
        .o_sprite_color (color3),
        .o_valid        (valid3),
        .o_frame        (frame3)
    );

    typedef struct {
        logic       req;
        logic [5:0] addr;
        logic       flip;
        logic       ev;
        logic       ec;
        string      nm;
    } vec_t;

    vec_t vt[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        req  = 1'b0;
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic read0();
        req  = 1'b1;
        addr = 6'd0;
        flip = 1'b0;
        step();
        req  = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a);
        req  = 1'b1;
        addr = a;
        flip = 1'b0;
        step();
        req  = 1'b0;
    endtask

    initial begin
        vt[0] = '{1'b1, 6'd4,  1'b0, 1'b1, 1'b1, "y0x4"};
        vt[1] = '{1'b1, 6'd0,  1'b0, 1'b1, 1'b0, "y0x0"};
        vt[2] = '{1'b1, 6'd3,  1'b0, 1'b1, 1'b0, "y0x3"};
        vt[3] = '{1'b0, 6'd4,  1'b0, 1'b0, 1'b0, "idle_hold0"};
        vt[4] = '{1'b1, 6'd3,  1'b1, 1'b1, 1'b1, "flip_y0x3"};
        vt[5] = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b1, "idle_hold1"};
        vt[6] = '{1'b1, 6'd63, 1'b1, 1'b1, 1'b0, "flip_y7x7"};
        vt[7] = '{1'b1, 6'd12, 1'b0, 1'b1, 1'b1, "y1x4"};
        vt[8] = '{1'b1, 6'd53, 1'b0, 1'b1, 1'b0, "f0_y6x5"};

        rst = 1'b1; addr = '0; req = 1'b0; flip = 1'b0;
        tick = 1'b0; anim_en = 1'b0; force_f = 1'b0; fidx = '0;
        step();
        step();
        chk("rst_valid", 32'(valid), 0);
        chk("rst_color", 32'(color), 0);
        chk("rst_frame", 32'(frame), 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            req  = vt[i].req;
            addr = vt[i].addr;
            flip = vt[i].flip;
            step();
            chk({vt[i].nm, "_valid"}, 32'(valid), 32'(vt[i].ev));
            chk({vt[i].nm, "_color"}, 32'(color), 32'(vt[i].ec));
        end
        req = 1'b0; flip = 1'b0;

        // animation: 5 ticks is not enough, the 6th steps the pending frame
        anim_en = 1'b1;
        ticks(5);
        read0();
        chk("tick5_frame", 32'(frame), 0);
        ticks(1);
        chk("pending_not_shown", 32'(frame), 0);
        read0();
        chk("tick6_frame", 32'(frame), 1);
        rd(6'd53);
        chk("f1_y6x5", 32'(color), 1);

        ticks(12);
        read0();
        chk("frame3", 32'(frame), 3);
        rd(6'd53);
        chk("f3_y6x5", 32'(color), 1);
        ticks(6);
        read0();
        chk("wrap_frame0", 32'(frame), 0);
        rd(6'd53);
        chk("f0_again_y6x5", 32'(color), 0);

        anim_en = 1'b0;
        ticks(20);
        read0();
        chk("anim_off_hold", 32'(frame), 0);

        // force alongside the wrapping tick
        anim_en = 1'b1;
        ticks(23);
        force_f = 1'b1; fidx = 2'd2; tick = 1'b1;
        step();
        force_f = 1'b0; tick = 1'b0;
        read0();
        chk("force_over_tick", 32'(frame), 2);
        ticks(5);
        read0();
        chk("force_cnt_clear", 32'(frame), 2);
        ticks(1);
        read0();
        chk("after_force_step", 32'(frame), 3);

        // force with a simultaneous addr-0 read sees the old pending frame
        force_f = 1'b1; fidx = 2'd1; req = 1'b1; addr = 6'd0;
        step();
        force_f = 1'b0; req = 1'b0;
        chk("force_same_read", 32'(frame), 3);
        read0();
        chk("force_next_read", 32'(frame), 1);

        // clamp on the 3-frame instance
        anim_en = 1'b0;
        force_f = 1'b1; fidx = 2'd3;
        step();
        force_f = 1'b0;
        read0();
        chk("clamp3_frame", 32'(frame3), 2);
        chk("clamp3_valid", 32'(valid3), 1);
        chk("noclamp4_frame", 32'(frame), 3);

        // reset mid-scan
        rd(6'd4);
        chk("pre_rst_color", 32'(color), 1);
        rst = 1'b1; req = 1'b1; addr = 6'd5;
        step();
        chk("midrst_valid", 32'(valid), 0);
        chk("midrst_color", 32'(color), 0);
        chk("midrst_frame", 32'(frame), 0);
        rst = 1'b0; req = 1'b0;

        anim_en = 1'b1;
        ticks(6);
        read0();
        chk("post_rst_step", 32'(frame), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
